cache_fill_fsm: RTL
===================

Name: cache_fill_fsm

Overview:
- Miss handler and initiator for the multi-cycle-read main memory (4-cycle read latency, data_valid strobe).
- On a cache miss it issues one read per cycle for every word of the missing block, then collects the returning words.
- It writes each returned word into the cache data array and writes the tag array once the block is complete.
- Sits between the I/D cache control logic and the shared main memory port.

Parameters:
- DWIDTH, 16, memory/cache data word width.
- AWIDTH, 16, byte address width.
- WORDS_PER_BLOCK, 8, words per cache block; power of two.
- MEM_LATENCY, 4, cycles from a read request being sampled to the matching data_valid.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- miss_detected  in  1  cache reports a miss this cycle.
- miss_address  in  AWIDTH  byte address that missed; sampled with miss_detected.
- fsm_busy  out  1  fill in progress; cache stalls the pipeline while high.
- memory_address  out  AWIDTH  byte address of the current read request (bit 0 always 0).
- memory_enable  out  1  read request valid.
- memory_wr  out  1  tied 0; this block never writes memory.
- memory_data_valid  in  1  memory read-return strobe.
- memory_data  in  DWIDTH  memory read-return data.
- write_data_array  out  1  write cache_data into the data array at cache_word_index.
- cache_word_index  out  log2(WORDS_PER_BLOCK)  word slot within the block.
- cache_data  out  DWIDTH  word to write; equals memory_data (combinational pass-through).
- write_tag_array  out  1  one-cycle pulse: block complete, commit the tag.

Behaviour:
- Reset (async, rst_n=0): state IDLE; both counters 0; fsm_busy, memory_enable, write_data_array, write_tag_array all 0; memory_address 0.
- States:
  - IDLE: on miss_detected, latch block_base = miss_address with the low log2(2*WORDS_PER_BLOCK) bits cleared, clear counters, go to FILL.
  - FILL: request and collection run concurrently.
  - Issue counter: while issue_cnt < WORDS_PER_BLOCK, drive memory_enable=1 and memory_address = block_base + 2*issue_cnt, then increment. This is one request per cycle, back-to-back, with no gaps.
  - Receive counter: each cycle memory_data_valid=1, assert write_data_array with cache_word_index=recv_cnt, then increment.
  - When the final word arrives (recv_cnt = WORDS_PER_BLOCK-1 with valid), assert write_tag_array in that same cycle and return to IDLE.
- fsm_busy is combinational: 1 whenever state=FILL.
- Timing for default parameters, with miss_detected in cycle 0:
  - Requests in cycles 1..8.
  - data_valid in cycles 5..12.
  - write_tag_array in cycle 12.
  - fsm_busy high in cycles 1..12, low in cycle 13.
  - Total fill = WORDS_PER_BLOCK + MEM_LATENCY cycles.
- miss_detected while in FILL is ignored; the cache re-presents the miss after fsm_busy falls.
- miss_detected in the same cycle as write_tag_array is ignored (state is still FILL).
- memory_data_valid while in IDLE is ignored: no array writes, no counter change.
- Counters are sized log2(WORDS_PER_BLOCK)+1 and never wrap during a fill.
- Address addition wraps modulo 2^AWIDTH; it cannot carry out of the block because block_base is aligned.
- Reset mid-fill: immediate return to IDLE, no tag write, and the partially filled block is left without a valid tag. The memory must be reset in the same window so that stale returns never reach a later fill.

Optional Feature:
- Macro: CACHE_FILL_CRITICAL_WORD_FIRST_EN.
- Defined: requests start at the missed word and wrap around the block. The word offset is off0 = miss_address[log2(2*WORDS_PER_BLOCK)-1:1].
  - Request i goes to block_base + 2*((off0+i) mod WORDS_PER_BLOCK).
  - cache_word_index = (off0+recv_cnt) mod WORDS_PER_BLOCK.
  - Latency and cycle count are unchanged.
- Undefined: every fill starts at word 0, as described above.

Decomposition:
- Shared package/include holds:
  - state encodings (IDLE=1'b0, FILL=1'b1);
  - WORDS_PER_BLOCK, OFFSET_BITS = log2(2*WORDS_PER_BLOCK), and WORD_IDX_BITS constants, so that the cache tag/index slicing uses the same values.
- One natural sub-module: block_word_counter, a clearable, enabled up-counter with a terminal-count output. Instantiated twice: issue and receive.

Test Plan:
- Basic fill, paired with the real memory model preloaded with mem[0x18+i]=0xA000+i:
  - miss_address=0x0034 -> requests at 0x0030..0x003E in cycles 1..8.
  - Data writes in cycles 5..12 with index 0..7, data 0xA000..0xA007.
  - write_tag_array pulse in cycle 12; fsm_busy low in cycle 13.
- Miss re-asserted in cycles 3 and 12 -> no restart, no extra requests; a new miss in cycle 13 starts a fresh fill with requests from cycle 14.
- Spurious memory_data_valid=1 while in IDLE -> write_data_array stays 0; the next fill still delivers indices 0..7.
- rst_n pulled low in cycle 6 -> all outputs 0 asynchronously, no write_tag_array; a fill after reset completes normally.
- Address-top wrap: miss_address=0xFFFE -> requests at 0xFFF0..0xFFFE; no address beyond 0xFFFE.
- With CACHE_FILL_CRITICAL_WORD_FIRST_EN defined: miss_address=0x0036 -> request order 0x36, 0x38, 0x3A, 0x3C, 0x3E, 0x30, 0x32, 0x34; indices 3..7, 0..2.

Source files
------------

// File: rtl/cache_fill_fsm_pkg.sv
// Shared constants and state encoding for the cache block fill logic.
// The cache tag/index slicing imports the same block geometry from here,
// so the fill engine and the tag logic can never disagree on alignment.
package cache_fill_fsm_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_t;

  // Default block geometry: 8 words of 16 bits, byte addressed.
  localparam int unsigned WORDS_PER_BLOCK = 8;
  localparam int unsigned OFFSET_BITS     = $clog2(2 * WORDS_PER_BLOCK);
  localparam int unsigned WORD_IDX_BITS   = $clog2(WORDS_PER_BLOCK);

endpackage

// File: rtl/cache_fill_fsm_counter.sv
// block_word_counter: clearable, enabled up-counter with a terminal-count flag.
// Used twice by cache_fill_fsm: once to pace read requests, once to
// count returning words.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clr         synchronous clear to zero (has priority over en)
//   en          increment by one
//   count       current count
//   at_limit    count == LIMIT
module block_word_counter
  import cache_fill_fsm_pkg::*;
#(
  parameter int unsigned WIDTH = WORD_IDX_BITS + 1,
  parameter int unsigned LIMIT = WORDS_PER_BLOCK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             at_limit
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign at_limit = (count == WIDTH'(LIMIT));

endmodule

// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: cache miss handler. On a miss it issues one read per
// cycle for every word of the aligned block, writes each returned word into
// the cache data array, and pulses the tag write when the last word lands.
// Optional build macro: CACHE_FILL_CRITICAL_WORD_FIRST_EN -- requests start
// at the missed word and wrap around the block.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   miss_detected      cache miss this cycle (miss_address sampled with it)
//   miss_address       byte address that missed
//   fsm_busy           fill in progress; pipeline stalls while high
//   memory_address     byte address of the current read request
//   memory_enable      read request valid
//   memory_wr          always 0; reads only
//   memory_data_valid  read-return strobe
//   memory_data        read-return data
//   write_data_array   write cache_data at cache_word_index
//   cache_word_index   word slot within the block
//   cache_data         word to write (pass-through of memory_data)
//   write_tag_array    one-cycle pulse: block complete, commit the tag
module cache_fill_fsm #(
  parameter int unsigned DWIDTH          = 16,
  parameter int unsigned AWIDTH          = 16,
  parameter int unsigned WORDS_PER_BLOCK = 8,
  parameter int unsigned MEM_LATENCY     = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               miss_detected,
  input  logic [AWIDTH-1:0]                  miss_address,
  output logic                               fsm_busy,
  output logic [AWIDTH-1:0]                  memory_address,
  output logic                               memory_enable,
  output logic                               memory_wr,
  input  logic                               memory_data_valid,
  input  logic [DWIDTH-1:0]                  memory_data,
  output logic                               write_data_array,
  output logic [$clog2(WORDS_PER_BLOCK)-1:0] cache_word_index,
  output logic [DWIDTH-1:0]                  cache_data,
  output logic                               write_tag_array
);

  import cache_fill_fsm_pkg::*;

  localparam int unsigned IDX_W = $clog2(WORDS_PER_BLOCK);
  localparam int unsigned CNT_W = IDX_W + 1;
  localparam int unsigned OFF_W = $clog2(2 * WORDS_PER_BLOCK);
  localparam logic [AWIDTH-1:0] BASE_MASK = {{(AWIDTH - OFF_W){1'b1}}, {OFF_W{1'b0}}};

  // The fill never stalls, so MEM_LATENCY only constrains legal parameter sets.
  if (MEM_LATENCY < 1 || WORDS_PER_BLOCK < 2 ||
      (WORDS_PER_BLOCK & (WORDS_PER_BLOCK - 1)) != 0) begin : g_param_check
    $error("cache_fill_fsm: unsupported parameter set");
  end

  fill_state_t        state, state_nxt;
  logic [AWIDTH-1:0]  block_base;
  logic [CNT_W-1:0]   issue_cnt, recv_cnt;
  logic               issue_done, recv_last;
  logic [IDX_W-1:0]   issue_word, recv_word;
  logic               cnt_clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      block_base <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && miss_detected) begin
        block_base <= miss_address & BASE_MASK;
      end
    end
  end

`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
  logic [IDX_W-1:0] off0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      off0 <= '0;
    end else if (state == IDLE && miss_detected) begin
      off0 <= miss_address[OFF_W-1:1];
    end
  end

  // IDX_W-bit sums wrap modulo WORDS_PER_BLOCK, giving the wrap-around order.
  assign issue_word = issue_cnt[IDX_W-1:0] + off0;
  assign recv_word  = recv_cnt[IDX_W-1:0] + off0;
`else
  assign issue_word = issue_cnt[IDX_W-1:0];
  assign recv_word  = recv_cnt[IDX_W-1:0];
`endif

  // Counters sit at zero throughout IDLE, so a miss always starts from 0.
  assign cnt_clr = (state == IDLE);

  block_word_counter #(
    .WIDTH (CNT_W),
    .LIMIT (WORDS_PER_BLOCK)
  ) u_issue_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (cnt_clr),
    .en       (memory_enable),
    .count    (issue_cnt),
    .at_limit (issue_done)
  );

  block_word_counter #(
    .WIDTH (CNT_W),
    .LIMIT (WORDS_PER_BLOCK - 1)
  ) u_recv_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (cnt_clr),
    .en       (write_data_array),
    .count    (recv_cnt),
    .at_limit (recv_last)
  );

  always_comb begin
    state_nxt        = state;
    fsm_busy         = 1'b0;
    memory_enable    = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    write_tag_array  = 1'b0;
    cache_word_index = recv_word;
    case (state)
      IDLE: begin
        if (miss_detected) begin
          state_nxt = FILL;
        end
      end
      FILL: begin
        fsm_busy = 1'b1;
        if (!issue_done) begin
          memory_enable  = 1'b1;
          memory_address = block_base + AWIDTH'({issue_word, 1'b0});
        end
        if (memory_data_valid) begin
          write_data_array = 1'b1;
          if (recv_last) begin
            write_tag_array = 1'b1;
            state_nxt       = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign memory_wr  = 1'b0;
  assign cache_data = memory_data;

endmodule
